// File: rtl/arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Fetch responses from unmapped addresses return NOP_INSTR.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RESP_I,
    ARB_RESP_D
  } arb_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/arb_sat_ctr.sv
// 32-bit saturating event counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module arb_sat_ctr (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q, cnt_d;

  // next count: clear wins, increment stops at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D).
// ARB_PERF_CNT_EN builds the stall counters; otherwise they read 0.
module unified_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           i_req,
  input  logic [31:0]                    i_addr,
  output logic                           i_gnt,
  output logic                           i_rvalid,
  output logic [31:0]                    i_rdata,
  input  logic                           d_req,
  input  logic                           d_we,
  input  logic [31:0]                    d_addr,
  input  logic [31:0]                    d_wdata,
  input  logic [3:0]                     d_wstrb,
  output logic                           d_gnt,
  output logic                           d_rvalid,
  output logic [31:0]                    d_rdata,
  output logic                           d_err,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
  output logic [31:0]                    mem_wdata,
  output logic [3:0]                     mem_wstrb,
  input  logic [31:0]                    mem_rdata,
  output logic [31:0]                    i_stall_cnt,
  output logic [31:0]                    d_stall_cnt
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned SW    = $clog2(MAX_D_STREAK + 1);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  arb_state_t    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          err_q, err_d;
  logic          st_q, st_d;
  logic          i_ok, d_ok;

  assign i_ok = {1'b0, i_addr} < LIMIT;
  assign d_ok = {1'b0, d_addr} < LIMIT;

  // grant selection and memory port drive
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (d_req && !(i_req && (streak_q == SW'(MAX_D_STREAK)))) begin
      d_gnt = 1'b1;
    end else if (i_req) begin
      i_gnt = 1'b1;
    end
    if (d_gnt) begin
      mem_en    = d_ok;
      mem_we    = d_ok && d_we;
      mem_addr  = d_addr[AW+1:2];
      mem_wdata = d_wdata;
      mem_wstrb = (d_ok && d_we) ? d_wstrb : 4'b0000;
    end else if (i_gnt) begin
      mem_en   = i_ok;
      mem_addr = i_addr[AW+1:2];
    end
  end

  // response owner, error/store flags and D streak tracking
  always_comb begin
    state_d  = ARB_IDLE;
    err_d    = 1'b0;
    st_d     = 1'b0;
    streak_d = streak_q;
    if (i_gnt) begin
      state_d = ARB_RESP_I;
      err_d   = !i_ok;
    end else if (d_gnt) begin
      state_d = ARB_RESP_D;
      err_d   = !d_ok;
      st_d    = d_we;
    end
    if (i_gnt || !i_req) begin
      streak_d = '0;
    end else if (d_gnt) begin
      streak_d = streak_q + SW'(1);
    end
  end

  // response outputs for the access granted last cycle
  always_comb begin
    i_rvalid = (state_q == ARB_RESP_I);
    d_rvalid = (state_q == ARB_RESP_D);
    i_rdata  = '0;
    d_rdata  = '0;
    d_err    = d_rvalid && err_q;
    if (i_rvalid) begin
      i_rdata = err_q ? NOP_INSTR : mem_rdata;
    end
    if (d_rvalid && !err_q && !st_q) begin
      d_rdata = mem_rdata;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ARB_IDLE;
      streak_q <= '0;
      err_q    <= 1'b0;
      st_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      err_q    <= err_d;
      st_q     <= st_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  arb_sat_ctr u_i_stall (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (1'b0),
    .inc   (i_req && !i_gnt),
    .cnt   (i_stall_cnt)
  );

  arb_sat_ctr u_d_stall (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (1'b0),
    .inc   (d_req && !d_gnt),
    .cnt   (d_stall_cnt)
  );
`else
  assign i_stall_cnt = '0;
  assign d_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed table, corner sequences,
// random traffic against a transaction-level reference model.
module tb_unified_mem_arbiter;

  localparam int DEPTH = 1024;
  localparam int MAXS  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] i_stall_cnt, d_stall_cnt;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.DEPTH_WORDS(DEPTH), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
  );

  // memory device attached to the arbiter
  logic [31:0] dmem [DEPTH];
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) dmem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= dmem[mem_addr];
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // reference model state
  logic [31:0] ref_mem [DEPTH];
  int      d_run;
  bit      p_i, p_d, p_err;
  logic [31:0] p_ir, p_dr;
  longint  si, sd;
  bit      eg_i, eg_d, i_in, d_in;

  function automatic logic [31:0] sat(input longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic model_reset();
    d_run = 0; p_i = 0; p_d = 0; p_err = 0; si = 0; sd = 0;
  endtask

  // called at negedge: compare DUT with the model
  task automatic check_now();
    logic [31:0] ea;
    logic en;
    i_in = i_addr < 32'(DEPTH * 4);
    d_in = d_addr < 32'(DEPTH * 4);
    eg_d = d_req && !(i_req && d_run >= MAXS);
    eg_i = i_req && !eg_d;
    en = (eg_i && i_in) || (eg_d && d_in);
    chk("i_gnt", 32'(i_gnt), 32'(eg_i));
    chk("d_gnt", 32'(d_gnt), 32'(eg_d));
    chk("mem_en", 32'(mem_en), 32'(en));
    if (en) begin
      ea = eg_d ? (d_addr >> 2) % DEPTH : (i_addr >> 2) % DEPTH;
      chk("mem_addr", 32'(mem_addr), ea);
      chk("mem_we", 32'(mem_we), 32'(eg_d && d_we));
      chk("mem_wstrb", 32'(mem_wstrb), (eg_d && d_we) ? 32'(d_wstrb) : 32'd0);
      if (eg_d && d_we) chk("mem_wdata", mem_wdata, d_wdata);
    end
    chk("i_rvalid", 32'(i_rvalid), 32'(p_i));
    if (p_i) chk("i_rdata", i_rdata, p_ir);
    chk("d_rvalid", 32'(d_rvalid), 32'(p_d));
    chk("d_err", 32'(d_err), 32'(p_d && p_err));
    if (p_d) chk("d_rdata", d_rdata, p_dr);
`ifdef ARB_PERF_CNT_EN
    chk("i_stall_cnt", i_stall_cnt, sat(si));
    chk("d_stall_cnt", d_stall_cnt, sat(sd));
`else
    chk("i_stall_cnt", i_stall_cnt, 32'd0);
    chk("d_stall_cnt", d_stall_cnt, 32'd0);
`endif
  endtask

  // called to cross the clock edge: advance the model by one transaction
  task automatic advance();
    int idx;
    @(posedge clk);
    if (eg_i || !i_req) d_run = 0;
    else if (eg_d)      d_run++;
    if (i_req && !eg_i) si++;
    if (d_req && !eg_d) sd++;
    p_i = eg_i; p_d = eg_d; p_err = 0;
    if (eg_i) begin
      idx = (i_addr >> 2) % DEPTH;
      p_ir = i_in ? ref_mem[idx] : NOP;
    end
    if (eg_d) begin
      idx = (d_addr >> 2) % DEPTH;
      p_err = !d_in;
      p_dr = (!d_in || d_we) ? 32'd0 : ref_mem[idx];
      if (d_in && d_we)
        for (int b = 0; b < 4; b++)
          if (d_wstrb[b]) ref_mem[idx][b*8 +: 8] = d_wdata[b*8 +: 8];
    end
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_now();
    advance();
  endtask

  task automatic idle_in();
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; d_wstrb = 0;
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr, dw;
    logic [31:0] da, dwd;
    logic [3:0]  ds;
    logic        eig, edg, een, ewe;
    logic [9:0]  ea;
    logic [3:0]  es;
  } vec_t;

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [31:0] da,
    input logic [31:0] dwd, input logic [3:0] ds,
    input logic eig, input logic edg, input logic een,
    input logic ewe, input logic [9:0] ea, input logic [3:0] es);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.dwd = dwd; v.ds = ds; v.eig = eig; v.edg = edg;
    v.een = een; v.ewe = ewe; v.ea = ea; v.es = es;
    return v;
  endfunction

  vec_t tv[$];

`ifdef ARB_PERF_CNT_EN
  localparam logic [31:0] STALL3 = 32'd3;
`else
  localparam logic [31:0] STALL3 = 32'd0;
`endif

  initial begin
    vec_t v;
    for (int k = 0; k < DEPTH; k++) begin
      dmem[k] = 32'hA500_0000 ^ (k * 32'h0001_0203);
      ref_mem[k] = dmem[k];
    end
    dmem[2] = 32'hDEAD_BEEF;
    ref_mem[2] = 32'hDEAD_BEEF;

    // directed table
    tv.push_back(mk(1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 1, 32'h10, 32'h1234_5678, 4'b0011,
                    0, 1, 1, 1, 4, 4'b0011));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 32'h1000, 0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(0, 0, 1, 0, 32'(k * 4), 0, 0, 0, 1, 1, 0, 10'(k), 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4)
        tv.push_back(mk(1, 32'hC, 1, 0, 32'h14, 0, 0, 1, 0, 1, 0, 3, 0));
      else
        tv.push_back(mk(1, 32'hC, 1, 0, 32'h14, 0, 0, 0, 1, 1, 0, 5, 0));
    end
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // reset state
    idle_in();
    n_rst = 0;
    model_reset();
    @(negedge clk);
    chk("rst_i_rvalid", 32'(i_rvalid), 0);
    chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_d_err", 32'(d_err), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_i_stall", i_stall_cnt, 0);
    @(posedge clk);
    #1 n_rst = 1;

    foreach (tv[n]) begin
      v = tv[n];
      i_req = v.ir; i_addr = v.ia; d_req = v.dr; d_we = v.dw;
      d_addr = v.da; d_wdata = v.dwd; d_wstrb = v.ds;
      @(negedge clk);
      chk($sformatf("tv%0d_i_gnt", n), 32'(i_gnt), 32'(v.eig));
      chk($sformatf("tv%0d_d_gnt", n), 32'(d_gnt), 32'(v.edg));
      chk($sformatf("tv%0d_mem_en", n), 32'(mem_en), 32'(v.een));
      if (v.een) begin
        chk($sformatf("tv%0d_mem_we", n), 32'(mem_we), 32'(v.ewe));
        chk($sformatf("tv%0d_mem_addr", n), 32'(mem_addr), 32'(v.ea));
        chk($sformatf("tv%0d_mem_wstrb", n), 32'(mem_wstrb), 32'(v.es));
      end
      check_now();
      advance();
    end

    // reset right after a load grant drops its response
    idle_in();
    d_req = 1; d_addr = 32'h4;
    cycle();
    d_req = 0;
    n_rst = 0;
    model_reset();
    @(negedge clk);
    chk("mid_rst_d_rvalid", 32'(d_rvalid), 0);
    chk("mid_rst_i_rvalid", 32'(i_rvalid), 0);
    @(posedge clk);
    #1 n_rst = 1;
    cycle();

    // three blocked fetch cycles
    i_req = 1; i_addr = 32'h20; d_req = 1; d_addr = 32'h24;
    repeat (3) cycle();
    idle_in();
    @(negedge clk);
    chk("i_stall_cnt3", i_stall_cnt, STALL3);
    check_now();
    advance();

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      i_req   = ($urandom_range(0, 3) != 0);
      i_addr  = (32'($urandom_range(0, 1100)) << 2) | 32'($urandom_range(0, 3));
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = $urandom_range(0, 1) != 0;
      d_addr  = (32'($urandom_range(0, 1100)) << 2) | 32'($urandom_range(0, 3));
      d_wdata = $urandom;
      d_wstrb = 4'($urandom_range(0, 15));
      cycle();
    end
    idle_in();
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
